// File: rtl/outlier_scatter_if.sv
// Row-in / beat-out bus for outlier_scatter.
// Both sides use valid/ready: a transfer happens on a rising clk edge where valid and ready are both high;
// valid never waits on ready, and payload stays stable while valid is high and ready is low.
interface outlier_scatter_if #(
   parameter int IN_WIDTH  = 16,
   parameter int IN_SIZE   = 4,
   parameter int IDX_WIDTH = $clog2(IN_SIZE)
);
   logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_in;
   logic [IN_SIZE-1:0]               mask_in;
   logic                             data_in_valid;
   logic                             data_in_ready;
   logic [IN_WIDTH-1:0]              data_out;
   logic [IDX_WIDTH-1:0]             index_out;
   logic                             last_out;
   logic                             empty_out;
   logic                             data_out_valid;
   logic                             data_out_ready;

   modport master (
      output data_in, mask_in, data_in_valid, data_out_ready,
      input  data_in_ready, data_out, index_out, last_out, empty_out, data_out_valid
   );

   modport slave (
      input  data_in, mask_in, data_in_valid, data_out_ready,
      output data_in_ready, data_out, index_out, last_out, empty_out, data_out_valid
   );
endinterface

// File: rtl/outlier_scatter.sv
// Compacts one masked row into a stream of (index, element) beats, lowest column first.
// Rows without any set mask bit still produce a single empty beat.
module outlier_scatter #(
   parameter int IN_WIDTH  = 16,
   parameter int IN_SIZE   = 4,
   parameter int IDX_WIDTH = $clog2(IN_SIZE)
) (
   input logic              clk,
   input logic              rst,
   outlier_scatter_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t                           state, state_n;
   logic [IN_SIZE-1:0][IN_WIDTH-1:0] row_q, row_n;
   logic [IN_SIZE-1:0]               pend_q, pend_n;
   logic                             in_hs, out_hs;

   function automatic logic [IDX_WIDTH-1:0] low_idx(input logic [IN_SIZE-1:0] m);
      logic [IDX_WIDTH-1:0] r;
      r = '0;
      for (int i = IN_SIZE - 1; i >= 0; i--) begin
         if (m[i]) r = IDX_WIDTH'(i);
      end
      return r;
   endfunction

   // A new row may land on the same edge the current row's last beat leaves.
   assign bus.data_in_ready = !rst &&
      (state == IDLE || (bus.data_out_valid && bus.last_out && bus.data_out_ready));
   assign in_hs  = bus.data_in_valid && bus.data_in_ready;
   assign out_hs = bus.data_out_valid && bus.data_out_ready;

   always_comb begin
      row_n   = row_q;
      pend_n  = pend_q;
      state_n = state;
      if (in_hs) begin
         row_n   = bus.data_in;
         pend_n  = bus.mask_in;
         state_n = EMIT;
      end else if (out_hs) begin
         pend_n = pend_q & ~(IN_SIZE'(1) << low_idx(pend_q));
         if (bus.last_out) state_n = IDLE;
      end
   end

   // Outputs are registered from the next-cycle view of the row and pending mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= IDLE;
         row_q              <= '0;
         pend_q             <= '0;
         bus.data_out_valid <= 1'b0;
         bus.data_out       <= '0;
         bus.index_out      <= '0;
         bus.last_out       <= 1'b0;
         bus.empty_out      <= 1'b0;
      end else begin
         state              <= state_n;
         row_q              <= row_n;
         pend_q             <= pend_n;
         bus.data_out_valid <= (state_n == EMIT);
         bus.last_out       <= (state_n == EMIT) && ((pend_n & (pend_n - IN_SIZE'(1))) == '0);
         bus.empty_out      <= (state_n == EMIT) && (pend_n == '0);
         if (state_n == EMIT && pend_n != '0) begin
            bus.data_out  <= row_n[low_idx(pend_n)];
            bus.index_out <= low_idx(pend_n);
         end else begin
            bus.data_out  <= '0;
            bus.index_out <= '0;
         end
      end
   end
endmodule

// File: tb/tb_outlier_scatter.sv
// Bench for outlier_scatter: directed rows plus random rows/backpressure, checked against a beat-queue model.
module tb_outlier_scatter;
   localparam int IN_WIDTH  = 16;
   localparam int IN_SIZE   = 4;
   localparam int IDX_WIDTH = 2;
   localparam int W         = 20;   // {empty, last, idx[1:0], data[15:0]}

   logic clk;
   logic rst;
   outlier_scatter_if #(.IN_WIDTH(IN_WIDTH), .IN_SIZE(IN_SIZE), .IDX_WIDTH(IDX_WIDTH)) bus ();

   outlier_scatter #(.IN_WIDTH(IN_WIDTH), .IN_SIZE(IN_SIZE), .IDX_WIDTH(IDX_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [W-1:0] exp_q[$];
   bit mon_en     = 1'b0;
   bit after_rst  = 1'b1;
   bit rand_ready = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: expand a row into its expected beats.
   task automatic model_push(input logic [IN_SIZE-1:0][IN_WIDTH-1:0] d, input logic [IN_SIZE-1:0] m);
      int hi;
      if (m == '0) begin
         exp_q.push_back({1'b1, 1'b1, 2'b00, 16'h0000});
      end else begin
         hi = 0;
         for (int c = 0; c < IN_SIZE; c++) if (m[c]) hi = c;
         for (int c = 0; c < IN_SIZE; c++)
            if (m[c]) exp_q.push_back({1'b0, (c == hi), 2'(c), d[c]});
      end
   endtask

   // scoreboard: outputs checked each negedge, model advanced for the coming edge
   always @(negedge clk) begin
      if (mon_en) begin
         logic [W-1:0] head;
         bit exp_valid, exp_ready;
         exp_valid = (exp_q.size() > 0);
         check_eq("data_out_valid", bus.data_out_valid, exp_valid);
         if (exp_valid) begin
            head = exp_q[0];
            check_eq("data_out",  bus.data_out,  head[15:0]);
            check_eq("index_out", bus.index_out, head[17:16]);
            check_eq("last_out",  bus.last_out,  head[18]);
            check_eq("empty_out", bus.empty_out, head[19]);
         end else if (after_rst) begin
            check_eq("rst_data_out",  bus.data_out,  0);
            check_eq("rst_index_out", bus.index_out, 0);
            check_eq("rst_last_out",  bus.last_out,  0);
            check_eq("rst_empty_out", bus.empty_out, 0);
         end
         exp_ready = !rst && (exp_q.size() == 0 || (exp_q.size() == 1 && bus.data_out_ready));
         check_eq("data_in_ready", bus.data_in_ready, exp_ready);
         if (rst) begin
            exp_q.delete();
            after_rst = 1'b1;
         end else begin
            if (exp_valid && bus.data_out_ready) void'(exp_q.pop_front());
            if (bus.data_in_valid && exp_ready) begin
               model_push(bus.data_in, bus.mask_in);
               after_rst = 1'b0;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         bus.data_out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // driver tasks
   task automatic send_row(input logic [IN_SIZE-1:0][IN_WIDTH-1:0] d, input logic [IN_SIZE-1:0] m);
      bus.data_in       = d;
      bus.mask_in       = m;
      bus.data_in_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (bus.data_in_ready) begin
            @(posedge clk); #1;
            return;
         end
         @(posedge clk); #1;
      end
      check_eq("input_handshake_timeout", 0, 1);
   endtask

   task automatic idle_in();
      bus.data_in_valid = 1'b0;
      bus.data_in       = {$urandom(), $urandom()};
      bus.mask_in       = 4'($urandom_range(0, 15));
   endtask

   task automatic drain();
      for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      check_eq("drain_remaining", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   logic [IN_SIZE-1:0][IN_WIDTH-1:0] row_a, row_r;

   initial begin
      rst = 1'b1;
      bus.data_out_ready = 1'b1;
      idle_in();
      row_a = {16'h5000, 16'h3800, 16'h4C00, 16'h3C00};
      @(posedge clk);
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      // two beats with free-flowing output
      send_row(row_a, 4'b1010);
      idle_in();
      drain();

      // first beat stalled three cycles
      bus.data_out_ready = 1'b0;
      send_row(row_a, 4'b1010);
      idle_in();
      repeat (3) begin @(posedge clk); #1; end
      bus.data_out_ready = 1'b1;
      drain();

      // empty row and full row
      send_row(row_a, 4'b0000);
      idle_in();
      drain();
      send_row(row_a, 4'b1111);
      idle_in();
      drain();

      // back-to-back rows, no bubble
      send_row(row_a, 4'b0100);
      send_row({16'h1111, 16'h2222, 16'h3333, 16'h4444}, 4'b0001);
      idle_in();
      drain();

      // reset mid-row
      send_row(row_a, 4'b1110);
      idle_in();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst_queue", exp_q.size(), 0);
      send_row(row_a, 4'b0001);
      idle_in();
      drain();

      // random rows with random backpressure and gaps
      rand_ready = 1'b1;
      for (int n = 0; n < 150; n++) begin
         row_r = {$urandom(), $urandom()};
         send_row(row_r, 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 2) == 0) begin
            idle_in();
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         end
      end
      idle_in();
      drain();
      rand_ready = 1'b0;
      bus.data_out_ready = 1'b1;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
